// File: rtl/score_pkg.sv
// Shared encodings and defaults for the pinball score controller.
package score_pkg;
  localparam int DIG_W         = 4;
  localparam int MAX_SCORE_DEF = 999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_CONV = 2'd2
  } state_t;
endpackage

// File: rtl/bcd_serial.sv
// Iterative binary to 3-digit BCD converter (double-dabble), one input bit per cycle.
module bcd_serial
  import score_pkg::*;
#(
  parameter int SCORE_W = 12
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [SCORE_W-1:0]   i_bin,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [3*DIG_W-1:0]   o_bcd_nxt
);
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCORE_W - 1);

  logic [SCORE_W-1:0] bin_q;
  logic [3*DIG_W-1:0] bcd_q;
  logic [3*DIG_W-1:0] adj;
  logic [CNT_W-1:0]   cnt_q;

  // o_bcd_nxt is the value after this cycle's step; on the last step it is the result.
  always_comb begin
    adj = bcd_q;
    for (int d = 0; d < 3; d++)
      if (bcd_q[d*DIG_W +: DIG_W] >= 4'd5)
        adj[d*DIG_W +: DIG_W] = bcd_q[d*DIG_W +: DIG_W] + 4'd3;
    o_bcd_nxt = {adj[3*DIG_W-2:0], bin_q[SCORE_W-1]};
    o_done    = o_busy && (cnt_q == LAST);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      o_busy <= 1'b0;
    end else if (i_start) begin
      bin_q  <= i_bin;
      bcd_q  <= '0;
      cnt_q  <= '0;
      o_busy <= 1'b1;
    end else if (o_busy) begin
      bcd_q <= o_bcd_nxt;
      bin_q <= {bin_q[SCORE_W-2:0], 1'b0};
      cnt_q <= cnt_q + 1'b1;
      if (o_done) o_busy <= 1'b0;
    end
  end
endmodule

// File: rtl/score_ctrl.sv
// Score register owner: round-robin point arbiter, saturating accumulator,
// serial BCD conversion and frame-synchronous digit display registers.
module score_ctrl
  import score_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int PTS_W     = 7,
  parameter int SCORE_W   = 12,
  parameter int MAX_SCORE = MAX_SCORE_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ani_stb,
  input  logic                     i_animate,
  input  logic                     i_clr,
  input  logic [N_SRC-1:0]         i_req,
  input  logic [N_SRC*PTS_W-1:0]   i_pts,
  output logic [N_SRC-1:0]         o_gnt,
  output logic [SCORE_W-1:0]       o_score,
  output logic [DIG_W-1:0]         o_hund,
  output logic [DIG_W-1:0]         o_tens,
  output logic [DIG_W-1:0]         o_ones,
  output logic                     o_busy
);
  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [SCORE_W:0] MAX_W = (SCORE_W+1)'(MAX_SCORE);

  state_t             state;
  logic [PTR_W-1:0]   ptr, gidx, ptr_nxt;
  logic               found;
  logic [PTS_W-1:0]   pts_q;
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] sat;
  logic [3*DIG_W-1:0] pend, conv_bcd;
  logic               pend_vld, conv_busy, conv_done, conv_start;
  int                 idx;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int i = 0; i < N_SRC; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!found && i_req[idx]) begin
        found = 1'b1;
        gidx  = PTR_W'(idx);
      end
    end
    ptr_nxt = (int'(gidx) == N_SRC - 1) ? '0 : gidx + 1'b1;
  end

  assign sum        = {1'b0, o_score} + {{(SCORE_W+1-PTS_W){1'b0}}, pts_q};
  assign sat        = (sum > MAX_W) ? MAX_W[SCORE_W-1:0] : sum[SCORE_W-1:0];
  assign conv_start = (state == ST_ADD) && !i_clr;
  assign o_busy     = (state != ST_IDLE);

  bcd_serial #(.SCORE_W(SCORE_W)) u_bcd (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (conv_start),
    .i_abort   (i_clr),
    .i_bin     (sat),
    .o_busy    (conv_busy),
    .o_done    (conv_done),
    .o_bcd_nxt (conv_bcd)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      pts_q    <= '0;
      o_gnt    <= '0;
      o_score  <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      o_hund   <= '0;
      o_tens   <= '0;
      o_ones   <= '0;
    end else begin
      o_gnt <= '0;
      // Display copy first so a same-cycle pend_vld set below wins and waits a frame.
      if (i_ani_stb && pend_vld) begin
        {o_hund, o_tens, o_ones} <= pend;
        pend_vld <= 1'b0;
      end
      if (i_clr) begin
        o_score  <= '0;
        pend     <= '0;
        pend_vld <= 1'b1;
        state    <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (i_animate && found) begin
            o_gnt <= N_SRC'(1) << gidx;
            pts_q <= i_pts[int'(gidx)*PTS_W +: PTS_W];
            ptr   <= ptr_nxt;
            state <= ST_ADD;
          end
          ST_ADD: begin
            o_score <= sat;
            state   <= ST_CONV;
          end
          ST_CONV: if (conv_done) begin
            pend     <= conv_bcd;
            pend_vld <= 1'b1;
            state    <= ST_IDLE;
          end else if (!conv_busy) begin
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_score_ctrl.sv
// Directed self-checking bench for score_ctrl: table of single adds plus corner sequences.
module tb_score_ctrl;
  localparam int N_SRC   = 4;
  localparam int PTS_W   = 7;
  localparam int SCORE_W = 12;

  logic                   i_clk = 1'b0;
  logic                   i_rst, i_ani_stb, i_animate, i_clr;
  logic [N_SRC-1:0]       i_req;
  logic [N_SRC*PTS_W-1:0] i_pts;
  logic [N_SRC-1:0]       o_gnt;
  logic [SCORE_W-1:0]     o_score;
  logic [3:0]             o_hund, o_tens, o_ones;
  logic                   o_busy;

  int ncmp = 0;
  int nerr = 0;

  typedef struct {
    int src;
    int pts;
    int score;
    int dig;   // expected {hund,tens,ones} as 12-bit hex
  } vec_t;
  vec_t tbl[11];

  score_ctrl #(.N_SRC(N_SRC), .PTS_W(PTS_W), .SCORE_W(SCORE_W), .MAX_SCORE(999)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ani_stb(i_ani_stb), .i_animate(i_animate),
    .i_clr(i_clr), .i_req(i_req), .i_pts(i_pts), .o_gnt(o_gnt), .o_score(o_score),
    .o_hund(o_hund), .o_tens(o_tens), .o_ones(o_ones), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic strobe();
    i_ani_stb = 1'b1;
    tick();
    i_ani_stb = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (2) tick();
    i_rst = 1'b0;
  endtask

  task automatic wait_gnt(output int n);
    logic ok;
    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (o_gnt != '0) begin
        n  = i;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("gnt_timeout", 0, 1);
  endtask

  function automatic int digs();
    return int'({o_hund, o_tens, o_ones});
  endfunction

  task automatic do_add(input int src, input int pts, input int exp_score, input int exp_dig);
    int n;
    i_pts[src*PTS_W +: PTS_W] = PTS_W'(pts);
    i_req[src] = 1'b1;
    wait_gnt(n);
    i_req[src] = 1'b0;
    chk("gnt_onehot", int'(o_gnt), 1 << src);
    tick();
    chk("score", int'(o_score), exp_score);
    chk("gnt_pulse", int'(o_gnt), 0);
    chk("busy_conv", int'(o_busy), 1);
    repeat (SCORE_W) @(posedge i_clk);
    #1;
    chk("busy_end", int'(o_busy), 0);
    strobe();
    chk("digits", digs(), exp_dig);
  endtask

  initial begin
    int n, seen;
    int order[5];
    int gap[5];

    tbl[0]  = '{2,  57,  57, 'h057};
    tbl[1]  = '{0, 100, 157, 'h157};
    tbl[2]  = '{3, 127, 284, 'h284};
    tbl[3]  = '{1, 127, 411, 'h411};
    tbl[4]  = '{2, 127, 538, 'h538};
    tbl[5]  = '{3, 127, 665, 'h665};
    tbl[6]  = '{0, 127, 792, 'h792};
    tbl[7]  = '{1, 127, 919, 'h919};
    tbl[8]  = '{0,  71, 990, 'h990};
    tbl[9]  = '{1, 100, 999, 'h999};
    tbl[10] = '{2,   5, 999, 'h999};

    i_rst = 1'b1; i_ani_stb = 1'b0; i_animate = 1'b1; i_clr = 1'b0;
    i_req = '0; i_pts = '0;
    do_reset();

    // reset state and idle strobes
    chk("rst_gnt", int'(o_gnt), 0);
    chk("rst_score", int'(o_score), 0);
    chk("rst_digits", digs(), 0);
    chk("rst_busy", int'(o_busy), 0);
    seen = 0;
    repeat (3) begin
      strobe();
      if (o_gnt != '0) seen++;
    end
    chk("idle_digits", digs(), 0);
    chk("idle_gnt", seen, 0);

    // single adds up to and past saturation
    foreach (tbl[i]) do_add(tbl[i].src, tbl[i].pts, tbl[i].score, tbl[i].dig);

    // reset clears a non-zero display
    do_reset();
    chk("rst2_score", int'(o_score), 0);
    chk("rst2_digits", digs(), 0);

    // round robin with all sources requesting one point
    for (int k = 0; k < N_SRC; k++) i_pts[k*PTS_W +: PTS_W] = PTS_W'(1);
    i_req = '1;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(n);
      gap[g] = n;
      order[g] = -1;
      for (int k = 0; k < N_SRC; k++) if (o_gnt == N_SRC'(1 << k)) order[g] = k;
    end
    i_req = '0;
    for (int g = 0; g < 5; g++) chk("rr_order", order[g], g % N_SRC);
    for (int g = 1; g < 5; g++) chk("rr_gap", gap[g], SCORE_W + 2);
    repeat (SCORE_W + 2) tick();
    chk("rr_score", int'(o_score), 5);
    strobe();
    chk("rr_digits", digs(), 'h005);

    // clear four cycles into CONV
    i_pts[1*PTS_W +: PTS_W] = PTS_W'(10);
    i_req[1] = 1'b1;
    wait_gnt(n);
    i_req[1] = 1'b0;
    repeat (4) tick();
    chk("clr_pre_score", int'(o_score), 15);
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    chk("clr_score", int'(o_score), 0);
    chk("clr_busy", int'(o_busy), 0);
    strobe();
    chk("clr_digits", digs(), 0);

    // strobe coinciding with the final conversion cycle
    i_pts[3*PTS_W +: PTS_W] = PTS_W'(20);
    i_req[3] = 1'b1;
    wait_gnt(n);
    i_req[3] = 1'b0;
    repeat (SCORE_W) @(posedge i_clk);
    #1;
    chk("gate_busy_last", int'(o_busy), 1);
    strobe();
    chk("gate_busy_idle", int'(o_busy), 0);
    chk("gate_digits_held", digs(), 0);
    strobe();
    chk("gate_digits_upd", digs(), 'h020);
    strobe();
    chk("gate_digits_stay", digs(), 'h020);

    // animate low blocks grants
    i_animate = 1'b0;
    i_pts[0*PTS_W +: PTS_W] = PTS_W'(3);
    i_req[0] = 1'b1;
    seen = 0;
    repeat (20) begin
      tick();
      if (o_gnt != '0) seen++;
    end
    chk("anim_gnt", seen, 0);
    chk("anim_busy", int'(o_busy), 0);
    chk("anim_score", int'(o_score), 20);
    i_animate = 1'b1;
    wait_gnt(n);
    i_req[0] = 1'b0;
    chk("anim_gnt_resume", int'(o_gnt), 1);
    tick();
    chk("anim_score_resume", int'(o_score), 23);
    repeat (SCORE_W + 2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
